// File: rtl/divide_pkg.sv
// Shared definitions for the sequential restoring divider and its
// subtract-compare-select step.
package divide_pkg;

    // Default operand/result width; one iteration is performed per bit.
    localparam int WIDTH = 8;

    // Iteration counter width for the default WIDTH.
    localparam int CNT_W = $clog2(WIDTH);

    // Control states of the divider.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/scs_step_ext.sv
// One restoring-division iteration: subtract the divisor from the shifted
// partial remainder, derive the quotient bit, and select the next remainder.
// ext is the bit shifted out of the top of the remainder. When it is set, the
// 9-bit shifted value is larger than d, so the subtraction always succeeds and
// the WIDTH-bit difference is exact.
module scs_step_ext
    import divide_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         ext,
    input  logic [W-1:0] rs,
    input  logic [W-1:0] d,
    output logic         qb,
    output logic [W-1:0] rnext
);

    logic [W-1:0] diff;
    logic         bout;

    // Ripple-borrow subtractor rs - d, producing diff and the final borrow.
    always_comb begin : ripple_sub
        logic borrow;
        // NOTE: every variable gets a value before any branch or loop reads it,
        // so no path can leave a stale value behind and infer a latch.
        borrow = 1'b0;
        diff   = '0;
        for (int i = 0; i < W; i++) begin
            // NOTE: blocking assignments are intended here; the borrow must
            // ripple from bit i into bit i+1 within a single evaluation.
            diff[i] = rs[i] ^ d[i] ^ borrow;
            borrow  = (~rs[i] & d[i]) | (~(rs[i] ^ d[i]) & borrow);
        end
        bout = borrow;
    end

    // The step succeeds when the shifted remainder is at least d.
    assign qb = ext | ~bout;

    // Per-bit 2:1 select: keep the difference on success, restore otherwise.
    assign rnext = qb ? diff : rs;

endmodule

// File: rtl/divide8_seq.sv
// Sequential unsigned restoring divider. A start in IDLE or DONE captures the
// operands; RUN then performs one subtract-compare-select step per clock for
// WIDTH clocks, and DONE presents the registered quotient and remainder for a
// single cycle. A zero divisor skips RUN and reports div_by_zero directly.
module divide8_seq #(
    parameter int WIDTH = divide_pkg::WIDTH
) (
    input  logic             drv_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    import divide_pkg::*;

    localparam int CNT_BITS = $clog2(WIDTH);
    localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(WIDTH - 1);

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0]    r_q,     r_d;      // partial remainder
    logic [WIDTH-1:0]    q_q,     q_d;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]    d_q,     d_d;      // captured divisor
    logic [WIDTH-1:0]    quot_q,  quot_d;
    logic [WIDTH-1:0]    rem_q,   rem_d;
    logic                dbz_q,   dbz_d;

    logic                step_ext;
    logic [WIDTH-1:0]    step_rs;
    logic                step_qb;
    logic [WIDTH-1:0]    step_rnext;

    // Shift {R, Q} left by one: the remainder's MSB becomes ext and the next
    // dividend bit enters the remainder's LSB.
    assign step_ext = r_q[WIDTH-1];
    assign step_rs  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    scs_step_ext #(
        .W (WIDTH)
    ) u_step (
        .ext   (step_ext),
        .rs    (step_rs),
        .d     (d_q),
        .qb    (step_qb),
        .rnext (step_rnext)
    );

    // Next-state logic: operand capture, one iteration per RUN cycle, result load.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    d_d   = divisor;
                    q_d   = dividend;
                    r_d   = '0;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                r_d   = step_rnext;
                q_d   = {q_q[WIDTH-2:0], step_qb};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    quot_d  = {q_q[WIDTH-2:0], step_qb};
                    rem_d   = step_rnext;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge drv_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_divide8_seq.sv
// Self-checking bench for divide8_seq: a table of directed divisions, hand
// sequences for mid-run restart, back-to-back start and mid-run reset, and an
// operand sweep compared against the bench's own integer division.
module tb_divide8_seq;

    logic       drv_clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quot;
    logic [7:0] rem;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    divide8_seq #(
        .WIDTH (8)
    ) dut (
        .drv_clk     (drv_clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quot        (quot),
        .rem         (rem),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 drv_clk = ~drv_clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
        logic       exp_z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one division, check the handshake timing, return the results seen
    // in the DONE cycle, then confirm done drops after one cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r, output logic z);
        int lat;
        logic seen;
        @(negedge drv_clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge drv_clk);
        #1;
        start = 1'b0;
        if (b == 8'd0) begin
            check("dz_done_after_accept", done, 1);
            check("dz_busy_low", busy, 0);
        end else begin
            check("busy_after_accept", busy, 1);
            check("no_early_done", done, 0);
            seen = 1'b0;
            lat  = 0;
            while (!seen && lat < 20) begin
                @(posedge drv_clk);
                #1;
                lat++;
                seen = done;
            end
            check("latency", lat, 8);
        end
        q = quot;
        r = rem;
        z = div_by_zero;
        @(posedge drv_clk);
        #1;
        check("done_one_cycle", done, 0);
        check("busy_low_after", busy, 0);
    endtask

    vec_t       vecs [8];
    logic [7:0] rq, rr;
    logic       rz;
    int         lat;
    logic [7:0] sa, sb;

    initial begin
        vecs[0] = '{a: 8'd200, b: 8'd7,   exp_q: 8'd28,  exp_r: 8'd4,   exp_z: 1'b0};
        vecs[1] = '{a: 8'd255, b: 8'd1,   exp_q: 8'd255, exp_r: 8'd0,   exp_z: 1'b0};
        vecs[2] = '{a: 8'd255, b: 8'd255, exp_q: 8'd1,   exp_r: 8'd0,   exp_z: 1'b0};
        vecs[3] = '{a: 8'd13,  b: 8'd200, exp_q: 8'd0,   exp_r: 8'd13,  exp_z: 1'b0};
        vecs[4] = '{a: 8'd255, b: 8'd128, exp_q: 8'd1,   exp_r: 8'd127, exp_z: 1'b0};
        vecs[5] = '{a: 8'd0,   b: 8'd9,   exp_q: 8'd0,   exp_r: 8'd0,   exp_z: 1'b0};
        vecs[6] = '{a: 8'd200, b: 8'd0,   exp_q: 8'hFF,  exp_r: 8'hC8,  exp_z: 1'b1};
        vecs[7] = '{a: 8'd200, b: 8'd7,   exp_q: 8'd28,  exp_r: 8'd4,   exp_z: 1'b0};

        // Reset state
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        #1 reset = 1'b1;
        #2;
        check("rst_quot", quot, 0);
        check("rst_rem", rem, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        repeat (2) @(posedge drv_clk);
        @(negedge drv_clk);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, rq, rr, rz);
            check($sformatf("vec%0d_quot", i), rq, vecs[i].exp_q);
            check($sformatf("vec%0d_rem", i), rr, vecs[i].exp_r);
            check($sformatf("vec%0d_dbz", i), rz, vecs[i].exp_z);
        end

        // start re-pulsed mid-run with new operands must be ignored
        @(negedge drv_clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        @(posedge drv_clk);
        #1;
        start = 1'b0;
        lat   = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge drv_clk);
            if (n == 3) begin
                start    = 1'b1;
                dividend = 8'd13;
                divisor  = 8'd200;
            end else begin
                start = 1'b0;
            end
            @(posedge drv_clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check("repulse_latency", lat, 8);
        check("repulse_quot", quot, 28);
        check("repulse_rem", rem, 4);

        // Back-to-back: start held in the DONE cycle
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd10;
        @(posedge drv_clk);
        #1;
        start = 1'b0;
        check("b2b_busy_rises", busy, 1);
        check("b2b_done_falls", done, 0);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge drv_clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check("b2b_latency", lat, 8);
        check("b2b_quot", quot, 10);
        check("b2b_rem", rem, 0);
        repeat (3) @(posedge drv_clk);
        #1;
        check("idle_hold_quot", quot, 10);
        check("idle_done_low", done, 0);

        // Reset asserted at iteration 4 of 200/7
        @(negedge drv_clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        @(posedge drv_clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge drv_clk);
        #2;
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_quot", quot, 0);
        check("mid_rst_rem", rem, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        for (int n = 0; n < 2; n++) begin
            @(posedge drv_clk);
            #1;
            check("rst_no_done", done, 0);
        end
        @(negedge drv_clk);
        reset = 1'b0;
        run_op(8'd50, 8'd3, rq, rr, rz);
        check("post_rst_quot", rq, 16);
        check("post_rst_rem", rr, 2);
        check("post_rst_dbz", rz, 0);

        // Operand sweep against integer division
        for (int k = 0; k < 2000; k++) begin
            sa = 8'($urandom_range(0, 255));
            sb = 8'($urandom_range(1, 255));
            run_op(sa, sb, rq, rr, rz);
            check($sformatf("sweep_quot %0d/%0d", sa, sb), rq, sa / sb);
            check($sformatf("sweep_rem %0d/%0d", sa, sb), rr, sa % sb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
